// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: requester identity, priority
// mode encodings and the request bundle that gets muxed onto the memory.
package dmem_arb_pkg;

    typedef enum logic {
        OWN_P0 = 1'b0,
        OWN_P1 = 1'b1
    } owner_e;

    localparam logic PRIO_RR    = 1'b0;
    localparam logic PRIO_FIXED = 1'b1;

    // Request bundle widths; the arbiter's AW/DW default to these.
    localparam int DMEM_AW = 32;
    localparam int DMEM_DW = 32;
    localparam int DMEM_MW = DMEM_DW / 8;

    typedef struct packed {
        logic               we;
        logic [DMEM_AW-1:0] addr;
        logic [DMEM_DW-1:0] wdata;
        logic [DMEM_MW-1:0] mask;
    } dmem_req_t;

endpackage

// File: rtl/arb_pick2.sv
// Two-way combinational picker: one-hot grant from requests, the previous
// owner, the priority mode and a lock override favouring port 1.
module arb_pick2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  owner_e     last_owner,
    input  logic       mode,
    input  logic       force_p1,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (force_p1 && req[1]) begin
            gnt = 2'b10;
        end else if (req == 2'b11) begin
            // On a tie, fixed mode always favours port 0; round-robin
            // favours whichever port did not own the memory last.
            if (mode == PRIO_FIXED || last_owner == OWN_P1) gnt = 2'b01;
            else                                            gnt = 2'b10;
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port synchronous-read data memory between the core
// load/store path (port 0) and a debug/DMA loader (port 1).
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW        = DMEM_AW,
    parameter int DW        = DMEM_DW,
    parameter int PRIO_MODE = 0,
    parameter int MAX_LOCK  = 16
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            p0_req,
    input  logic            p0_we,
    input  logic [AW-1:0]   p0_addr,
    input  logic [DW-1:0]   p0_wdata,
    input  logic [DW/8-1:0] p0_mask,
    output logic            p0_gnt,
    output logic            p0_rvalid,
    output logic [DW-1:0]   p0_rdata,

    input  logic            p1_req,
    input  logic            p1_we,
    input  logic [AW-1:0]   p1_addr,
    input  logic [DW-1:0]   p1_wdata,
    input  logic [DW/8-1:0] p1_mask,
    input  logic            p1_lock,
    output logic            p1_gnt,
    output logic            p1_rvalid,
    output logic [DW-1:0]   p1_rdata,

    output logic            mem_en,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_mask,
    input  logic [DW-1:0]   mem_rdata
);

    localparam int MW  = DW / 8;
    localparam int LCW = $clog2(MAX_LOCK + 1);

    owner_e           last_owner_q, last_owner_d;
    owner_e           rd_owner_q,   rd_owner_d;
    logic             rd_pending_q, rd_pending_d;
    logic             p1_prev_q,    p1_prev_d;
    logic [LCW-1:0]   lock_cnt_q,   lock_cnt_d;
    logic [DW-1:0]    p0_rdata_q,   p0_rdata_d;
    logic [DW-1:0]    p1_rdata_q,   p1_rdata_d;

    logic [1:0]       pick_gnt;
    logic [1:0]       gnt;
    logic             force_p1;
    dmem_req_t        r0, r1, sel;

    // A burst keeps port 1 only while it owned the previous cycle and has
    // not yet used up its lock budget.
    assign force_p1 = p1_prev_q && p1_lock && (lock_cnt_q < LCW'(MAX_LOCK));

    arb_pick2 u_pick (
        .req        ({p1_req, p0_req}),
        .last_owner (last_owner_q),
        .mode       ((PRIO_MODE != 0) ? PRIO_FIXED : PRIO_RR),
        .force_p1   (force_p1),
        .gnt        (pick_gnt)
    );

    // No grant may escape while reset is held, even with requests raised.
    assign gnt    = pick_gnt & {2{rst}};
    assign p0_gnt = gnt[0];
    assign p1_gnt = gnt[1];

    always_comb begin
        r0  = '{we: p0_we, addr: DMEM_AW'(p0_addr), wdata: DMEM_DW'(p0_wdata), mask: DMEM_MW'(p0_mask)};
        r1  = '{we: p1_we, addr: DMEM_AW'(p1_addr), wdata: DMEM_DW'(p1_wdata), mask: DMEM_MW'(p1_mask)};
        sel = '0;
        if (gnt[1])      sel = r1;
        else if (gnt[0]) sel = r0;
    end

    assign mem_en    = |gnt;
    assign mem_we    = sel.we;
    assign mem_addr  = AW'(sel.addr);
    assign mem_wdata = DW'(sel.wdata);
    assign mem_mask  = MW'(sel.mask);

    // Read data lands one cycle after the grant; the idle port keeps its last word.
    assign p0_rvalid = rd_pending_q && (rd_owner_q == OWN_P0);
    assign p1_rvalid = rd_pending_q && (rd_owner_q == OWN_P1);
    assign p0_rdata  = p0_rvalid ? mem_rdata : p0_rdata_q;
    assign p1_rdata  = p1_rvalid ? mem_rdata : p1_rdata_q;

    always_comb begin
        last_owner_d = last_owner_q;
        rd_owner_d   = rd_owner_q;
        rd_pending_d = mem_en && !mem_we;
        p1_prev_d    = gnt[1];
        lock_cnt_d   = '0;
        p0_rdata_d   = p0_rdata;
        p1_rdata_d   = p1_rdata;

        if (gnt[0]) last_owner_d = OWN_P0;
        if (gnt[1]) last_owner_d = OWN_P1;
        if (mem_en) rd_owner_d = gnt[1] ? OWN_P1 : OWN_P0;

        // A grant taken at the limit starts a fresh burst count.
        if (gnt[1] && p1_lock) begin
            if (lock_cnt_q >= LCW'(MAX_LOCK)) lock_cnt_d = LCW'(1);
            else                              lock_cnt_d = lock_cnt_q + LCW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_owner_q <= OWN_P1;
            rd_owner_q   <= OWN_P0;
            rd_pending_q <= 1'b0;
            p1_prev_q    <= 1'b0;
            lock_cnt_q   <= '0;
            p0_rdata_q   <= '0;
            p1_rdata_q   <= '0;
        end else begin
            last_owner_q <= last_owner_d;
            rd_owner_q   <= rd_owner_d;
            rd_pending_q <= rd_pending_d;
            p1_prev_q    <= p1_prev_d;
            lock_cnt_q   <= lock_cnt_d;
            p0_rdata_q   <= p0_rdata_d;
            p1_rdata_q   <= p1_rdata_d;
        end
    end

endmodule
